mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 64-bit RISC-V pipeline, sitting between the EX/MEM pipeline register and the MEM/WB register. It consumes the registered EX/MEM fields, runs loads and stores over a request/response data-memory port, and byte-lane-aligns and sign- or zero-extends load data. It raises a stall request to pipeline control while an access is outstanding. Non-memory instructions pass through to MEM/WB in the same cycle.

## Interface
- No parameters. Widths come from shared defines: RegBus 64, AddrBus 64, RegAddrBus 5, OpcodeBus 7, FunctBus3 3.
- clk  in  1  clock; the block uses one clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr_i  in  5  destination register, from EX/MEM.
- wreg_i  in  1  rd write flag, from EX/MEM.
- wdata_i  in  64  ALU result; this is the effective address for loads and stores.
- store_data_i  in  64  rs2 value, from EX/MEM.
- pc_i  in  64  instruction PC; Invalid_pc marks a bubble.
- opcode_i  in  7  instruction opcode.
- funct3_i  in  3  instruction funct3.
- rd_addr_o  out  5  to MEM/WB.
- wreg_o  out  1  to MEM/WB.
- wdata_o  out  64  ALU result, or extended load data, to MEM/WB.
- pc_o  out  64  to MEM/WB.
- mem_stall_req_o  out  1  to pipeline control; 1 holds EX/MEM in Block and bubbles MEM/WB.
- dmem_req_o  out  1  request valid.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  64  byte address (wdata_i).
- dmem_wdata_o  out  64  store data shifted into its byte lanes.
- dmem_wmask_o  out  8  byte-enable mask.
- dmem_ready_i  in  1  request accepted.
- dmem_rvalid_i  in  1  response valid (load data or store ack).
- dmem_rdata_i  in  64  aligned 64-bit doubleword.
- misalign_o  out  1  misaligned access flag (only with the macro).

## Operation
- Memory op: opcode_i is Opcode_Load (0000011) or Opcode_Store (0100011) and pc_i is not Invalid_pc.
- Access size comes from funct3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = double.
  - Loads use funct3[2]=1 for zero-extend (LBU, LHU, LWU).
  - Stores ignore funct3[2].
- Lane shift is off = wdata_i[2:0].
  - dmem_wmask_o = (1/3/0xF/0xFF) << off.
  - dmem_wdata_o = store_data_i << (8*off).
- Load data: take dmem_rdata_i >> (8*off), truncate to size, then sign- or zero-extend to 64 bits.
- FSM states IDLE, REQ_WAIT, RESP_WAIT, DONE. Reset state is IDLE.
  - IDLE: on a memory op, drive dmem_req_o=1 combinationally.
    - dmem_ready_i=1 and dmem_rvalid_i=1 in the same cycle: go to DONE.
    - dmem_ready_i=1 only: go to RESP_WAIT.
    - Otherwise: go to REQ_WAIT.
  - REQ_WAIT: hold dmem_req_o and all request fields stable until dmem_ready_i. Exit as from IDLE.
  - RESP_WAIT: dmem_req_o=0. On dmem_rvalid_i, capture the extended load data into load_q and go to DONE.
  - DONE: present the result with the stall released. Always go to IDLE next cycle.
- mem_stall_req_o = memory op && state != DONE.
- While stalled: wreg_o = write-disable, rd_addr_o = 0, pc_o = Invalid_pc, wdata_o = 0.
- In DONE:
  - Load: wdata_o = load_q.
  - Store: wreg_o = write-disable, wdata_o = 0.
  - pc_o = pc_i.
- Non-memory op in IDLE: all outputs pass through combinationally. No stall.
- dmem_rvalid_i in IDLE or REQ_WAIT is ignored.
- Reset mid-access: the FSM returns to IDLE and load_q is cleared. The data-memory model is reset by the same rst.

## Timing
- Reset values: state IDLE, load_q 0, dmem_req_o 0, mem_stall_req_o 0, misalign_o 0.
- Outputs are not independently reset. They pass through EX/MEM's reset values (Opcode_InValid, Invalid_pc).
- Non-memory op: 0-cycle latency through this stage.
- Minimum memory-op residency is 2 cycles (IDLE with same-cycle ready and rvalid, then DONE).
- Residency is 2 plus the ready-wait cycles plus the rvalid-wait cycles.
- Exactly one dmem_req_o/dmem_ready_i handshake per memory op.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - A memory op whose address is not a multiple of its size issues no request.
  - misalign_o=1 for one cycle, the FSM goes straight to DONE, and the op retires with write-disable.
- Undefined:
  - No check; misalign_o is tied 0.
  - A request that would cross a doubleword sends a mask truncated to 8 bits; behaviour beyond that is the software's responsibility.

## Structure
- Shared defines.v gains the following; existing opcode, funct3, Invalid_pc and write-enable defines are reused:
  - MemSize constants: MEM_B, MEM_H, MEM_W, MEM_D.
  - FSM state encodings: MEM_IDLE, MEM_REQ_WAIT, MEM_RESP_WAIT, MEM_DONE.
- Sub-module mem_lane_align: purely combinational mask, store shift, and load extract/extend.
- FSM and load_q use the existing Reg primitive.

## Test plan
- ADDI result 0x1234 to rd=5, pc=0x80000000 -> same-cycle outputs wdata_o=0x1234, rd_addr_o=5, mem_stall_req_o=0.
- LB at addr 0x1003, rdata=0x00000000_80000000, ready and rvalid in the same cycle -> stall for 1 cycle, then DONE with wdata_o=0xFFFFFFFFFFFFFF80.
- LHU at addr 0x2002, ready delayed 2 cycles, rvalid 3 cycles after that:
  - Required: stall for 6 cycles, wdata_o zero-extended, exactly one handshake.
- SW of 0xDEADBEEF at addr 0x3004:
  - Required: dmem_wmask_o=0xF0 and dmem_wdata_o=0xDEADBEEF_00000000.
  - wreg_o disabled in DONE.
- rst asserted while in RESP_WAIT -> next cycle state IDLE, mem_stall_req_o=0, load_q=0.
- With MEM_MISALIGN_CHECK_EN: LW at addr 0x4002 -> no dmem_req_o, misalign_o=1 for one cycle, no register write.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, opcodes, sentinel values, access-size and
// FSM-state enums for the 64-bit RISC-V memory-access stage.
package mem_stage_pkg;

   localparam int unsigned RegBus     = 64;
   localparam int unsigned AddrBus    = 64;
   localparam int unsigned RegAddrBus = 5;
   localparam int unsigned OpcodeBus  = 7;
   localparam int unsigned FunctBus3  = 3;

   localparam logic [OpcodeBus-1:0] Opcode_Load    = 7'b0000011;
   localparam logic [OpcodeBus-1:0] Opcode_Store   = 7'b0100011;
   localparam logic [OpcodeBus-1:0] Opcode_InValid = 7'b0000000;

   localparam logic [AddrBus-1:0] Invalid_pc = '0;

   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;

   // Access size, encoded as funct3[1:0].
   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10,
      MEM_D = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      MEM_IDLE      = 2'b00,
      MEM_REQ_WAIT  = 2'b01,
      MEM_RESP_WAIT = 2'b10,
      MEM_DONE      = 2'b11
   } mem_state_e;

   // True when the low address bits are not a multiple of the access size.
   function automatic logic addr_misaligned(input logic [2:0] off, input mem_size_e size);
      logic r;
      case (size)
         MEM_B:   r = 1'b0;
         MEM_H:   r = off[0];
         MEM_W:   r = |off[1:0];
         default: r = |off;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational byte-lane logic for the memory stage.
//   off_i        in  3   byte offset within the doubleword (addr[2:0])
//   size_i       in  2   access size (mem_size_e)
//   zext_i       in  1   1 = zero-extend load data, 0 = sign-extend
//   store_data_i in  64  rs2 value to be stored
//   rdata_i      in  64  aligned doubleword returned by memory
//   wmask_o      out 8   byte-enable mask shifted into place
//   wdata_o      out 64  store data shifted into its byte lanes
//   load_o       out 64  extracted and extended load data
module mem_lane_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]        off_i,
   input  mem_size_e         size_i,
   input  logic              zext_i,
   input  logic [RegBus-1:0] store_data_i,
   input  logic [RegBus-1:0] rdata_i,
   output logic [7:0]        wmask_o,
   output logic [RegBus-1:0] wdata_o,
   output logic [RegBus-1:0] load_o
);

   logic [7:0]        base_mask;
   logic [5:0]        bit_shift;
   logic [RegBus-1:0] rshift;

   assign bit_shift = {off_i, 3'b000};

   always_comb begin
      case (size_i)
         MEM_B:   base_mask = 8'h01;
         MEM_H:   base_mask = 8'h03;
         MEM_W:   base_mask = 8'h0F;
         default: base_mask = 8'hFF;
      endcase
   end

   // An access that would cross the doubleword simply loses its upper lanes.
   assign wmask_o = base_mask << off_i;
   assign wdata_o = store_data_i << bit_shift;
   assign rshift  = rdata_i >> bit_shift;

   always_comb begin
      case (size_i)
         MEM_B:   load_o = zext_i ? {56'b0, rshift[7:0]}  : {{56{rshift[7]}},  rshift[7:0]};
         MEM_H:   load_o = zext_i ? {48'b0, rshift[15:0]} : {{48{rshift[15]}}, rshift[15:0]};
         MEM_W:   load_o = zext_i ? {32'b0, rshift[31:0]} : {{32{rshift[31]}}, rshift[31:0]};
         default: load_o = rshift;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX/MEM and MEM/WB.
// Runs loads/stores over a request/response data-memory port, stalls the
// pipeline while an access is outstanding, and passes non-memory
// instructions straight through in the same cycle.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   rd_addr_i/wreg_i/wdata_i   EX/MEM destination, write flag, ALU result (address)
//   store_data_i, pc_i         rs2 value, instruction PC (Invalid_pc = bubble)
//   opcode_i, funct3_i         instruction decode fields
//   rd_addr_o/wreg_o/wdata_o/pc_o  MEM/WB fields
//   mem_stall_req_o            stall request to pipeline control
//   dmem_*                     data-memory request/response port
//   misalign_o                 misaligned-access flag
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned accesses
// (no request issued, misalign_o pulses, op retires without a write).
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RegAddrBus-1:0] rd_addr_i,
   input  logic                  wreg_i,
   input  logic [RegBus-1:0]     wdata_i,
   input  logic [RegBus-1:0]     store_data_i,
   input  logic [AddrBus-1:0]    pc_i,
   input  logic [OpcodeBus-1:0]  opcode_i,
   input  logic [FunctBus3-1:0]  funct3_i,
   output logic [RegAddrBus-1:0] rd_addr_o,
   output logic                  wreg_o,
   output logic [RegBus-1:0]     wdata_o,
   output logic [AddrBus-1:0]    pc_o,
   output logic                  mem_stall_req_o,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [AddrBus-1:0]    dmem_addr_o,
   output logic [RegBus-1:0]     dmem_wdata_o,
   output logic [7:0]            dmem_wmask_o,
   input  logic                  dmem_ready_i,
   input  logic                  dmem_rvalid_i,
   input  logic [RegBus-1:0]     dmem_rdata_i,
   output logic                  misalign_o
);

   mem_state_e        state_q, state_d;
   logic [RegBus-1:0] load_q, load_d;
   logic [RegBus-1:0] load_ext;
   logic              is_load, is_store, mem_op, misaligned;
   mem_size_e         size;

   assign is_load  = (opcode_i == Opcode_Load);
   assign is_store = (opcode_i == Opcode_Store);
   assign mem_op   = (is_load || is_store) && (pc_i != Invalid_pc);
   assign size     = mem_size_e'(funct3_i[1:0]);

   assign dmem_we_o   = is_store;
   assign dmem_addr_o = wdata_i;

   mem_lane_align u_align (
      .off_i        (wdata_i[2:0]),
      .size_i       (size),
      .zext_i       (funct3_i[2] & is_load),
      .store_data_i (store_data_i),
      .rdata_i      (dmem_rdata_i),
      .wmask_o      (dmem_wmask_o),
      .wdata_o      (dmem_wdata_o),
      .load_o       (load_ext)
   );

`ifdef MEM_MISALIGN_CHECK_EN
   logic misalign_q;
   assign misaligned = mem_op && addr_misaligned(wdata_i[2:0], size);
   // Set only on the IDLE->DONE trap transition, so it lasts exactly the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= (state_q == MEM_IDLE) && misaligned;
   end
   assign misalign_o = misalign_q;
`else
   assign misaligned = 1'b0;
   assign misalign_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MEM_IDLE;
         load_q  <= '0;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      load_d     = load_q;
      dmem_req_o = 1'b0;
      case (state_q)
         MEM_IDLE, MEM_REQ_WAIT: begin
            if (mem_op || state_q == MEM_REQ_WAIT) begin
               if (misaligned) begin
                  state_d = MEM_DONE;
               end else begin
                  dmem_req_o = 1'b1;
                  // rvalid only counts when it accompanies the accepting ready.
                  if (dmem_ready_i && dmem_rvalid_i) begin
                     state_d = MEM_DONE;
                     if (is_load) load_d = load_ext;
                  end else if (dmem_ready_i) begin
                     state_d = MEM_RESP_WAIT;
                  end else begin
                     state_d = MEM_REQ_WAIT;
                  end
               end
            end
         end
         MEM_RESP_WAIT: begin
            if (dmem_rvalid_i) begin
               state_d = MEM_DONE;
               if (is_load) load_d = load_ext;
            end
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   always_comb begin
      mem_stall_req_o = mem_op && (state_q != MEM_DONE);
      rd_addr_o       = rd_addr_i;
      wreg_o          = wreg_i;
      wdata_o         = wdata_i;
      pc_o            = pc_i;
      if (mem_stall_req_o) begin
         rd_addr_o = '0;
         wreg_o    = WriteDisable;
         wdata_o   = '0;
         pc_o      = Invalid_pc;
      end else if (mem_op && state_q == MEM_DONE) begin
         if (is_store || misalign_o) begin
            wreg_o  = WriteDisable;
            wdata_o = '0;
         end else begin
            wdata_o = load_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rd_addr_i;
   logic        wreg_i;
   logic [63:0] wdata_i, store_data_i, pc_i;
   logic [6:0]  opcode_i;
   logic [2:0]  funct3_i;
   logic [4:0]  rd_addr_o;
   logic        wreg_o;
   logic [63:0] wdata_o, pc_o;
   logic        mem_stall_req_o, dmem_req_o, dmem_we_o;
   logic [63:0] dmem_addr_o, dmem_wdata_o;
   logic [7:0]  dmem_wmask_o;
   logic        dmem_ready_i, dmem_rvalid_i;
   logic [63:0] dmem_rdata_i;
   logic        misalign_o;

   int checks = 0;
   int errors = 0;
   int stall_cycles;
   int handshakes;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst(rst),
      .rd_addr_i(rd_addr_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
      .store_data_i(store_data_i), .pc_i(pc_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
      .rd_addr_o(rd_addr_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .pc_o(pc_o),
      .mem_stall_req_o(mem_stall_req_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
      .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .misalign_o(misalign_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] sdata, input logic [4:0] rd, input logic [63:0] pc);
      opcode_i = op; funct3_i = f3; wdata_i = addr; store_data_i = sdata;
      rd_addr_i = rd; wreg_i = 1'b1; pc_i = pc;
   endtask

   initial begin
      rst = 1'b1;
      drive(Opcode_InValid, 3'd0, 64'h0, 64'h0, 5'd0, Invalid_pc);
      wreg_i = 1'b0;
      dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_state", {62'b0, dut.state_q}, {62'b0, MEM_IDLE});
      check("reset_load_q", dut.load_q, 64'h0);
      check("reset_stall", {63'b0, mem_stall_req_o}, 64'd0);
      check("reset_req", {63'b0, dmem_req_o}, 64'd0);
      check("reset_misalign", {63'b0, misalign_o}, 64'd0);
      rst = 1'b0;

      // ADDI passes through in the same cycle
      @(negedge clk);
      drive(7'b0010011, 3'd0, 64'h1234, 64'h0, 5'd5, 64'h8000_0000);
      #1;
      check("addi_wdata", wdata_o, 64'h1234);
      check("addi_rd", {59'b0, rd_addr_o}, 64'd5);
      check("addi_stall", {63'b0, mem_stall_req_o}, 64'd0);
      check("addi_wreg", {63'b0, wreg_o}, 64'd1);
      check("addi_pc", pc_o, 64'h8000_0000);
      check("addi_req", {63'b0, dmem_req_o}, 64'd0);

      // LB 0x1003, same-cycle ready+rvalid: byte 0x80 sign-extends
      @(negedge clk);
      drive(Opcode_Load, 3'b000, 64'h1003, 64'h0, 5'd6, 64'h8000_0004);
      dmem_ready_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h0000_0000_8000_0000;
      #1;
      check("lb_stall", {63'b0, mem_stall_req_o}, 64'd1);
      check("lb_req", {63'b0, dmem_req_o}, 64'd1);
      check("lb_addr", dmem_addr_o, 64'h1003);
      check("lb_stall_pc", pc_o, Invalid_pc);
      check("lb_stall_wreg", {63'b0, wreg_o}, 64'd0);
      check("lb_stall_rd", {59'b0, rd_addr_o}, 64'd0);
      @(negedge clk);
      dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      #1;
      check("lb_done_stall", {63'b0, mem_stall_req_o}, 64'd0);
      check("lb_done_req", {63'b0, dmem_req_o}, 64'd0);
      check("lb_done_wdata", wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
      check("lb_done_rd", {59'b0, rd_addr_o}, 64'd6);
      check("lb_done_wreg", {63'b0, wreg_o}, 64'd1);
      check("lb_done_pc", pc_o, 64'h8000_0004);

      // LHU 0x2002: ready on 3rd cycle, rvalid 3 cycles later; stray rvalid in IDLE ignored
      @(negedge clk);
      drive(Opcode_Load, 3'b101, 64'h2002, 64'h0, 5'd7, 64'h8000_0008);
      dmem_rdata_i = 64'h1234_5678_9ABC_DEF0;
      stall_cycles = 0; handshakes = 0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge clk);
         dmem_ready_i  = (c == 2);
         dmem_rvalid_i = (c == 0) || (c == 5);
         #1;
         if (!mem_stall_req_o) break;
         stall_cycles++;
         if (dmem_req_o && dmem_ready_i) handshakes++;
      end
      check("lhu_stall_cycles", 64'(stall_cycles), 64'd6);
      check("lhu_handshakes", 64'(handshakes), 64'd1);
      check("lhu_wdata", wdata_o, 64'h0000_0000_0000_9ABC);
      check("lhu_wreg", {63'b0, wreg_o}, 64'd1);
      check("lhu_req_done", {63'b0, dmem_req_o}, 64'd0);

      // SW 0xDEADBEEF at 0x3004
      @(negedge clk);
      drive(Opcode_Store, 3'b010, 64'h3004, 64'h0000_0000_DEAD_BEEF, 5'd9, 64'h8000_000C);
      dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      #1;
      check("sw_req", {63'b0, dmem_req_o}, 64'd1);
      check("sw_we", {63'b0, dmem_we_o}, 64'd1);
      check("sw_mask", {56'b0, dmem_wmask_o}, 64'h0F0);
      check("sw_wdata", dmem_wdata_o, 64'hDEAD_BEEF_0000_0000);
      @(negedge clk);
      dmem_ready_i = 1'b1; dmem_rvalid_i = 1'b1;
      #1;
      check("sw_reqwait_req", {63'b0, dmem_req_o}, 64'd1);
      check("sw_reqwait_mask", {56'b0, dmem_wmask_o}, 64'h0F0);
      @(negedge clk);
      dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0;
      #1;
      check("sw_done_stall", {63'b0, mem_stall_req_o}, 64'd0);
      check("sw_done_wreg", {63'b0, wreg_o}, 64'd0);
      check("sw_done_wdata", wdata_o, 64'h0);
      check("sw_done_pc", pc_o, 64'h8000_000C);

      // LD accepted, then reset while waiting for the response
      @(negedge clk);
      drive(Opcode_Load, 3'b011, 64'h5000, 64'h0, 5'd10, 64'h8000_0010);
      dmem_ready_i = 1'b1;
      @(negedge clk);
      dmem_ready_i = 1'b0;
      #1;
      check("ld_respwait_state", {62'b0, dut.state_q}, {62'b0, MEM_RESP_WAIT});
      check("ld_respwait_req", {63'b0, dmem_req_o}, 64'd0);
      check("ld_respwait_stall", {63'b0, mem_stall_req_o}, 64'd1);
      rst = 1'b1;
      drive(Opcode_InValid, 3'd0, 64'h0, 64'h0, 5'd0, Invalid_pc);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mid_state", {62'b0, dut.state_q}, {62'b0, MEM_IDLE});
      check("rst_mid_stall", {63'b0, mem_stall_req_o}, 64'd0);
      check("rst_mid_load_q", dut.load_q, 64'h0);

`ifdef MEM_MISALIGN_CHECK_EN
      @(negedge clk);
      drive(Opcode_Load, 3'b010, 64'h4002, 64'h0, 5'd11, 64'h8000_0014);
      #1;
      check("mis_req", {63'b0, dmem_req_o}, 64'd0);
      check("mis_flag_idle", {63'b0, misalign_o}, 64'd0);
      @(negedge clk);
      #1;
      check("mis_flag_done", {63'b0, misalign_o}, 64'd1);
      check("mis_wreg", {63'b0, wreg_o}, 64'd0);
      check("mis_stall", {63'b0, mem_stall_req_o}, 64'd0);
      @(negedge clk);
      drive(Opcode_InValid, 3'd0, 64'h0, 64'h0, 5'd0, Invalid_pc);
      #1;
      check("mis_flag_after", {63'b0, misalign_o}, 64'd0);
`else
      @(negedge clk);
      drive(Opcode_Load, 3'b010, 64'h4002, 64'h0, 5'd11, 64'h8000_0014);
      #1;
      check("nochk_misalign", {63'b0, misalign_o}, 64'd0);
      check("nochk_req", {63'b0, dmem_req_o}, 64'd1);
      check("nochk_mask", {56'b0, dmem_wmask_o}, 64'h03C);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
